// File: rtl/regfile_sb_pkg.sv
// Shared CPU constants for the register file and its load scoreboard.
// Holds register-index names and the address range helper.
package regfile_sb_pkg;

    localparam int REG_AW = 5;
    localparam int CPU_DW = 32;
    localparam int NSLOT  = 1 << REG_AW;

    localparam logic [REG_AW-1:0] ZERO = 5'd0;
    localparam logic [REG_AW-1:0] RA   = 5'd31;

    // Addresses at or above the configured register count do not exist.
    function automatic logic addr_valid(input logic [REG_AW-1:0] a, input int nreg);
        return (int'(a) < nreg);
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-load bits and the source-operand stall.
// A set and a clear on the same register in one cycle leaves it pending.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] RA1,
    input  logic [REG_AW-1:0] RA2,
    input  logic              WE,
    input  logic [REG_AW-1:0] WA,
    input  logic              SB_SET,
    input  logic [REG_AW-1:0] SB_ADDR,
    output logic              STALL,
    output logic [NSLOT-1:0]  PEND
);

    logic [NSLOT-1:0] pend_q;
    logic [NSLOT-1:0] pend_d;
    logic [NSLOT-1:0] set_vec;
    logic [NSLOT-1:0] clr_vec;
    logic             byp1;
    logic             byp2;
    logic             hit1;
    logic             hit2;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (SB_SET && (SB_ADDR != ZERO) && addr_valid(SB_ADDR, NREG)) begin
            set_vec[SB_ADDR] = 1'b1;
        end
        if (WE) begin
            clr_vec[WA] = 1'b1;
        end
        pend_d = (pend_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // A write retiring this cycle resolves the hazard when it can be forwarded.
    assign byp1  = BYPASS && WE && (WA == RA1);
    assign byp2  = BYPASS && WE && (WA == RA2);
    assign hit1  = pend_q[RA1] && !byp1;
    assign hit2  = pend_q[RA2] && !byp2;
    assign STALL = hit1 | hit2;
    assign PEND  = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// 32x32 register file, two combinational reads, one write, with forwarding
// and a pending-load scoreboard that stalls consumers of outstanding loads.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DW     = regfile_sb_pkg::CPU_DW,
    parameter int NREG   = 32,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] RA1,
    input  logic [REG_AW-1:0] RA2,
    output logic [DW-1:0]     RD1,
    output logic [DW-1:0]     RD2,
    input  logic              WE,
    input  logic [REG_AW-1:0] WA,
    input  logic [DW-1:0]     WD,
    input  logic              SB_SET,
    input  logic [REG_AW-1:0] SB_ADDR,
    output logic              STALL,
    output logic [NSLOT-1:0]  PEND
);

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (WE && (WA == r[REG_AW-1:0])) begin
                    regs_q[r] <= WD;
                end
            end
        end
    end

    // Outputs are forced to zero while reset is held, even if a write is presented.
    always_comb begin
        RD1 = '0;
        if (rst_n && (RA1 != ZERO) && addr_valid(RA1, NREG)) begin
            RD1 = regs_q[RA1];
            if (BYPASS && WE && (WA == RA1)) begin
                RD1 = WD;
            end
        end
    end

    always_comb begin
        RD2 = '0;
        if (rst_n && (RA2 != ZERO) && addr_valid(RA2, NREG)) begin
            RD2 = regs_q[RA2];
            if (BYPASS && WE && (WA == RA2)) begin
                RD2 = WD;
            end
        end
    end

    regfile_scoreboard #(
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .RA1     (RA1),
        .RA2     (RA2),
        .WE      (WE),
        .WA      (WA),
        .SB_SET  (SB_SET),
        .SB_ADDR (SB_ADDR),
        .STALL   (STALL),
        .PEND    (PEND)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: array/bit-vector reference model checked every
// falling edge, plus literal expectations at the interesting points.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  ra1, ra2, wa, sb_addr;
    logic [31:0] wd;
    logic        we, sb_set;
    logic [31:0] rd1, rd2, pend;
    logic        stall;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_reg  [32];
    logic        m_pend [32];

    always #5 clk = ~clk;

    regfile_sb #(.DW(32), .NREG(32), .BYPASS(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RA1     (ra1),
        .RA2     (ra2),
        .RD1     (rd1),
        .RD2     (rd2),
        .WE      (we),
        .WA      (wa),
        .WD      (wd),
        .SB_SET  (sb_set),
        .SB_ADDR (sb_addr),
        .STALL   (stall),
        .PEND    (pend)
    );

    // Reference: a plain array of values and a plain array of pending flags.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i]  <= 32'd0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            if (we && wa != 5'd0) m_reg[wa] <= wd;
            if (we) m_pend[wa] <= 1'b0;
            if (sb_set && sb_addr != 5'd0) m_pend[sb_addr] <= 1'b1;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (we && wa == a) return wd;
        return m_reg[a];
    endfunction

    function automatic logic exp_stall();
        logic h1, h2;
        h1 = m_pend[ra1] && !(we && wa == ra1);
        h2 = m_pend[ra2] && !(we && wa == ra2);
        return h1 || h2;
    endfunction

    function automatic logic [31:0] exp_pend();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model_rd1",   rd1, exp_rd(ra1));
        check("model_rd2",   rd2, exp_rd(ra2));
        check("model_stall", {31'd0, stall}, {31'd0, exp_stall()});
        check("model_pend",  pend, exp_pend());
    end

    task automatic drv(input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic s, input logic [4:0] sa,
                       input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        we = w; wa = a; wd = d; sb_set = s; sb_addr = sa; ra1 = r1; ra2 = r2;
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        we = 0; wa = 0; wd = 0; sb_set = 0; sb_addr = 0; ra1 = 0; ra2 = 0;
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'd0;
            m_pend[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        drv(0, 0, 0, 0, 0, 5, RA);
        check("reset_rd1", rd1, 32'd0);
        check("reset_rd2", rd2, 32'd0);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_pend", pend, 32'd0);

        drv(1, ZERO, 32'hFFFF_FFFF, 1, ZERO, ZERO, ZERO);
        check("r0_bypass_rd1", rd1, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 0);
        check("r0_rd1", rd1, 32'd0);
        check("r0_pend", pend, 32'd0);
        check("r0_stall", {31'd0, stall}, 32'd0);

        drv(1, 7, 32'h8000_0000, 0, 0, 7, 0);
        check("byp_r7_same", rd1, 32'h8000_0000);
        drv(0, 0, 0, 0, 0, 7, 0);
        check("byp_r7_next", rd1, 32'h8000_0000);

        drv(0, 0, 0, 1, 9, 0, 9);
        check("issue_nostall", {31'd0, stall}, 32'd0);
        drv(0, 0, 0, 0, 0, 0, 9);
        check("r9_stall", {31'd0, stall}, 32'd1);
        check("r9_pend", pend, 32'h0000_0200);
        drv(0, 0, 0, 0, 0, 0, 9);
        drv(0, 0, 0, 0, 0, 0, 9);
        check("r9_stall_hold", {31'd0, stall}, 32'd1);
        drv(1, 9, 32'hA5A5_A5A5, 0, 0, 0, 9);
        check("r9_resolve_stall", {31'd0, stall}, 32'd0);
        check("r9_resolve_rd2", rd2, 32'hA5A5_A5A5);
        drv(0, 0, 0, 0, 0, 0, 9);
        check("r9_cleared_pend", pend, 32'd0);
        check("r9_cleared_rd2", rd2, 32'hA5A5_A5A5);

        drv(1, 4, 32'h0000_0044, 1, 4, 0, 0);
        drv(0, 0, 0, 0, 0, 4, 0);
        check("setwins_stall", {31'd0, stall}, 32'd1);
        check("setwins_rd1", rd1, 32'h0000_0044);
        check("setwins_pend", pend, 32'h0000_0010);
        drv(1, 4, 32'h0000_0045, 0, 0, 0, 0);

        drv(0, 0, 0, 1, 2, 0, 0);
        drv(0, 0, 0, 1, 3, 0, 0);
        drv(0, 0, 0, 0, 0, 2, 3);
        check("two_pend", pend, 32'h0000_000C);
        check("two_stall", {31'd0, stall}, 32'd1);
        drv(1, 2, 32'h22, 0, 0, 2, 3);
        check("r2_only_stall", {31'd0, stall}, 32'd1);
        check("r2_only_rd1", rd1, 32'h22);
        drv(1, 3, 32'h33, 0, 0, 2, 3);
        check("r3_resolve_stall", {31'd0, stall}, 32'd0);
        check("r3_resolve_rd2", rd2, 32'h33);
        drv(0, 0, 0, 0, 0, 2, 3);
        check("both_clear_pend", pend, 32'd0);

        drv(1, 3, 32'h1234, 1, 10, 0, 0);
        drv(0, 0, 0, 0, 0, 3, 10);
        check("pre_rst_rd1", rd1, 32'h1234);
        check("pre_rst_stall", {31'd0, stall}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rd1", rd1, 32'd0);
        check("async_rst_stall", {31'd0, stall}, 32'd0);
        check("async_rst_pend", pend, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drv(0, 0, 0, 0, 0, 3, 10);
        check("post_rst_rd1", rd1, 32'd0);
        check("post_rst_stall", {31'd0, stall}, 32'd0);

        for (int n = 0; n < 300; n++) begin
            drv(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        drv(0, 0, 0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- 32x32 general-purpose register file with two combinational read ports and one synchronous write port.
- Includes a per-register pending-write scoreboard.
- Sits directly upstream of the shifter/ALU: RD1 drives the shifter data operand (ALU_DA), RD2 drives the second ALU operand.
- The scoreboard raises STALL when a source register awaits an outstanding load. This prepares the single-cycle core for a multi-cycle data memory.

Parameters:
- DW, 32, data width of each register.
- NREG, 32, number of registers; the address width is log2(NREG) = 5.
- BYPASS, 1, when 1, same-cycle write data is forwarded to the read ports and the scoreboard clear.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- RA1  in  5  read address, port 1 (rs).
- RA2  in  5  read address, port 2 (rt).
- RD1  out  32  read data, port 1; feeds ALU_DA.
- RD2  out  32  read data, port 2.
- WE  in  1  write enable.
- WA  in  5  write address.
- WD  in  32  write data.
- SB_SET  in  1  marks register SB_ADDR pending (load issued).
- SB_ADDR  in  5  register to mark pending.
- STALL  out  1  a source register is pending and not being resolved this cycle.
- PEND  out  32  pending bit vector (debug/verification).

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset:
  - All registers are cleared to 0 asynchronously and all pending bits to 0.
  - RD1/RD2 read 0, STALL=0, PEND=0 while rst_n=0.
  - Release is sampled at the next rising clk. Reset mid-load discards the pending state, so no stall follows.
- Register 0:
  - Always reads 0.
  - Writes to WA=0 are ignored.
  - SB_SET with SB_ADDR=0 is ignored; PEND[0] is always 0.
- Write: on a rising clk with WE=1 and WA!=0, reg[WA] <= WD.
- Read:
  - RDn = reg[RAn], combinational.
  - If BYPASS=1 and WE=1, WA=RAn and WA!=0, then RDn = WD in the same cycle. Both ports may bypass simultaneously.
  - If BYPASS=0, the new value is visible from the next cycle.
- Scoreboard update per register r, at the rising clk:
  - clr = WE && WA==r; set = SB_SET && SB_ADDR==r.
  - set=1: pend[r] <= 1. Set wins over a simultaneous clear, because a new load overlaps the retiring write.
  - clr=1, set=0: pend[r] <= 0.
  - Otherwise pend[r] holds.
- STALL (combinational):
  - hitn = pend[RAn] && !(BYPASS && WE && WA==RAn).
  - STALL = hit1 | hit2.
  - RA=0 never stalls.
  - SB_SET in the current cycle does not affect STALL until the next cycle; the issuing instruction itself is never stalled.
- Latency:
  - Read: 0 cycles.
  - Write to visible: 0 cycles with BYPASS=1, 1 cycle with BYPASS=0.
  - Pending bit: set/cleared 1 cycle after the event.
- Width rules:
  - No arithmetic is performed.
  - Addresses are full 5-bit; out-of-range values do not exist when NREG=32.
  - If NREG<32, addresses >= NREG read 0 and ignore writes and sets.

Decomposition:
- Shared CPU package holds:
  - REG_AW=5 and DW=32.
  - Register-index constants (ZERO=0, RA=31).
- Natural sub-module: regfile_scoreboard. It contains the pend vector, set/clear logic and STALL generation.
- The top instantiates it next to the storage array and the bypass muxes.

Test Plan:
- Reset, then read RA1=5, RA2=31 -> RD1=0, RD2=0, STALL=0, PEND=0. Assert rst_n=0 mid-run with reg3=0x1234 -> RD reads 0 immediately, before any clk edge.
- WE=1, WA=0, WD=0xFFFFFFFF, then RA1=0 -> RD1=0. Also SB_SET with SB_ADDR=0 -> PEND[0]=0, STALL=0.
- WE=1, WA=7, WD=0x80000000, RA1=7, same cycle -> RD1=0x80000000 (BYPASS=1), or the old value then 0x80000000 next cycle (BYPASS=0).
- SB_SET, SB_ADDR=9; next cycle RA2=9 -> STALL=1. Three cycles later WE=1, WA=9, WD=0xA5A5A5A5 -> STALL=0 that cycle (BYPASS=1), RD2=0xA5A5A5A5, PEND[9]=0 after the edge.
- Same cycle WE=1, WA=4 and SB_SET, SB_ADDR=4 -> after the edge reg4=WD and PEND[4]=1. RA1=4 next cycle -> STALL=1.
- Pending on r2 and r3; RA1=2, RA2=3; write r2 only -> STALL stays 1 via r3. Write r3 next -> STALL=0.
